// File: rtl/sng_mux_stream_pkg.sv
// Shared types and helpers for the stochastic number generator slice.
package sc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    // Widest operand any generator instance may be built with.
    localparam int MAX_W = 8;

    // Stream length: a full 2^W-bit window, or one bit shorter with no tail.
    function automatic int sc_len(input int w, input int tail_zero);
        return (tail_zero != 0) ? (1 << w) : ((1 << w) - 1);
    endfunction

    // Operand bit selected at stream position k: W-1 minus the number of
    // trailing ones of k. A result of -1 means k is all ones (tail position).
    function automatic int trailing_ones(input logic [MAX_W-1:0] k, input int w);
        int   t;
        logic run;
        t   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_W; i++) begin
            if ((i < w) && run) begin
                if (k[i]) begin
                    t = t + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return w - 1 - t;
    endfunction

endpackage

// File: rtl/sng_mux_stream_sel_gen.sv
// Converts the stream position into the operand bit index to select, plus a
// flag for the all-ones (tail) position. One instance serves every channel.
module sng_sel_gen
    import sc_pkg::*;
#(
    parameter int W     = 4,
    parameter int SEL_W = $clog2(W)
) (
    input  logic [W-1:0]     i_cnt,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_tail
);

    logic [MAX_W-1:0] w_cntExt;
    int               w_selIdx;

    // Trailing-ones decode of the position into a select index.
    always_comb begin
        w_cntExt          = '0;
        w_cntExt[W-1:0]   = i_cnt;
        w_selIdx          = trailing_ones(w_cntExt, W);
        o_tail            = (w_selIdx < 0);
        o_sel             = '0;
        if (!o_tail) begin
            o_sel = SEL_W'(w_selIdx);
        end
    end

endmodule

// File: rtl/sng_mux_stream.sv
// Binary-to-stochastic generator: latches N_CH operands on a valid/ready
// handshake and emits one deterministic unipolar bit per channel per cycle.
module sng_mux_stream
    import sc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int W         = 4,
    parameter int TAIL_ZERO = 1
) (
    input  logic                   i_clk_sng,
    input  logic                   i_rst_sng_n,
    input  logic [N_CH-1:0][W-1:0] i_x,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_stop,
    output logic                   o_valid,
    output logic [N_CH-1:0]        o_sn_bit,
    output logic [W-1:0]           o_idx,
    output logic                   o_last
);

    localparam int             LEN      = sc_len(W, TAIL_ZERO);
    localparam logic [W-1:0]   LAST_IDX = W'(LEN - 1);
    localparam int             SEL_W    = $clog2(W);

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [W-1:0]           r_cnt;
    logic [W-1:0]           w_cntNext;
    logic [N_CH-1:0][W-1:0] r_hold;
    logic [N_CH-1:0][W-1:0] w_holdNext;
    logic                   w_atLast;
    logic                   w_accept;
    logic [SEL_W-1:0]       w_sel;
    logic                   w_tail;

    assign w_atLast = (r_cnt == LAST_IDX);
    assign o_ready  = (r_state == IDLE) || ((r_state == GEN) && w_atLast);
    assign w_accept = i_valid && o_ready;
    assign o_valid  = (r_state == GEN);
    assign o_idx    = r_cnt;
    assign o_last   = o_valid && w_atLast;

    sng_sel_gen #(
        .W     (W),
        .SEL_W (SEL_W)
    ) u_sel_gen (
        .i_cnt  (r_cnt),
        .o_sel  (w_sel),
        .o_tail (w_tail)
    );

    // Every channel picks the same bit position out of its own held operand.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign o_sn_bit[c] = o_valid && !w_tail && r_hold[c][w_sel];
    end

    // State, position counter and operand hold register.
    always_ff @(posedge i_clk_sng or negedge i_rst_sng_n) begin
        if (!i_rst_sng_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_hold  <= w_holdNext;
        end
    end

    // Next state: accept starts or chains a stream, stop aborts without o_last.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_holdNext  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_stateNext = GEN;
                    w_cntNext   = '0;
                    w_holdNext  = i_x;
                end
            end
            GEN: begin
                if (w_atLast) begin
                    w_cntNext = '0;
                    if (w_accept) begin
                        w_holdNext = i_x;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else if (i_stop) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + W'(1);
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sng_mux_stream.sv
// Directed bench for sng_mux_stream in three configurations.
module tb_sng_mux_stream;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    // Clock shared by all three instances.
    always #5 clk = ~clk;

    // Instance A: N_CH=4, W=4, TAIL_ZERO=1
    logic [3:0][3:0] aX;
    logic            aValid, aStop, aReady, aOValid, aLast;
    logic [3:0]      aBit, aIdx;

    // Instance B: N_CH=1, W=3, TAIL_ZERO=0
    logic [0:0][2:0] bX;
    logic            bValid, bStop, bReady, bOValid, bLast;
    logic [0:0]      bBit;
    logic [2:0]      bIdx;

    // Instance C: N_CH=8, W=6, TAIL_ZERO=1
    logic [7:0][5:0] cX;
    logic            cValid, cStop, cReady, cOValid, cLast;
    logic [7:0]      cBit;
    logic [5:0]      cIdx;

    int checks = 0;
    int errors = 0;

    sng_mux_stream #(.N_CH(4), .W(4), .TAIL_ZERO(1)) dutA (
        .i_clk_sng(clk), .i_rst_sng_n(rst_n), .i_x(aX), .i_valid(aValid),
        .o_ready(aReady), .i_stop(aStop), .o_valid(aOValid),
        .o_sn_bit(aBit), .o_idx(aIdx), .o_last(aLast)
    );

    sng_mux_stream #(.N_CH(1), .W(3), .TAIL_ZERO(0)) dutB (
        .i_clk_sng(clk), .i_rst_sng_n(rst_n), .i_x(bX), .i_valid(bValid),
        .o_ready(bReady), .i_stop(bStop), .o_valid(bOValid),
        .o_sn_bit(bBit), .o_idx(bIdx), .o_last(bLast)
    );

    sng_mux_stream #(.N_CH(8), .W(6), .TAIL_ZERO(1)) dutC (
        .i_clk_sng(clk), .i_rst_sng_n(rst_n), .i_x(cX), .i_valid(cValid),
        .o_ready(cReady), .i_stop(cStop), .o_valid(cOValid),
        .o_sn_bit(cBit), .o_idx(cIdx), .o_last(cLast)
    );

    // One-cycle handshake on instance A; returns one tick into the idx-0 cycle.
    task automatic start_a(input logic [3:0][3:0] x);
        @(posedge clk);
        #1;
        aX     = x;
        aValid = 1'b1;
        @(posedge clk);
        #1;
        aValid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({aOValid, aBit, aIdx, aLast} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b exp=%b", {aOValid, aBit, aIdx, aLast}, 10'b0);
        end
        checks++;
        if ({bOValid, cOValid, bLast, cLast, cBit} !== 12'b0) begin
            errors++;
            $display("[TB] FAIL reset_other got=%b exp=%b", {bOValid, cOValid, bLast, cLast, cBit}, 12'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({aReady, aOValid, bReady, cReady} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL reset_release got=%b exp=%b", {aReady, aOValid, bReady, cReady}, 4'b1011);
        end
    endtask

    task automatic test_single_stream();
        logic [3:0][15:0] mask;
        logic [3:0]       expBits;
        int               ones[4];
        int               expOnes[4];
        mask[0] = 16'h7FFF;
        mask[1] = 16'h5555;
        mask[2] = 16'h0080;
        mask[3] = 16'h0000;
        expOnes = '{15, 8, 1, 0};
        ones    = '{0, 0, 0, 0};
        start_a({4'd0, 4'd1, 4'd8, 4'd15});
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                expBits[c] = mask[c][k];
                if (aBit[c]) ones[c]++;
            end
            checks++;
            if ({aOValid, aIdx, aLast, aReady} !== {1'b1, 4'(k), (k == 15), (k == 15)}) begin
                errors++;
                $display("[TB] FAIL single_ctl k=%0d got=%b exp=%b", k,
                         {aOValid, aIdx, aLast, aReady}, {1'b1, 4'(k), (k == 15), (k == 15)});
            end
            checks++;
            if (aBit !== expBits) begin
                errors++;
                $display("[TB] FAIL single_bits k=%0d got=%b exp=%b", k, aBit, expBits);
            end
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ones[c] != expOnes[c]) begin
                errors++;
                $display("[TB] FAIL single_ones ch=%0d got=%0d exp=%0d", c, ones[c], expOnes[c]);
            end
        end
        @(negedge clk);
        checks++;
        if ({aOValid, aReady, aBit, aLast} !== 7'b0100000) begin
            errors++;
            $display("[TB] FAIL single_idle got=%b exp=%b", {aOValid, aReady, aBit, aLast}, 7'b0100000);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m5;
        logic [15:0] m10;
        logic [15:0] m;
        logic [3:0]  expBits;
        int          ks;
        int          ones0[4];
        int          ones1[4];
        m5    = 16'h22A2;
        m10   = 16'h5D5D;
        ones0 = '{0, 0, 0, 0};
        ones1 = '{0, 0, 0, 0};
        @(posedge clk);
        #1;
        aX     = {4{4'd5}};
        aValid = 1'b1;
        @(posedge clk);
        #1;
        aX = {4{4'd10}};
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            ks      = k % 16;
            m       = (k < 16) ? m5 : m10;
            expBits = {4{m[ks]}};
            for (int c = 0; c < 4; c++) begin
                if (aBit[c]) begin
                    if (k < 16) ones0[c]++;
                    else ones1[c]++;
                end
            end
            checks++;
            if ({aOValid, aIdx, aLast, aReady} !== {1'b1, 4'(ks), (ks == 15), (ks == 15)}) begin
                errors++;
                $display("[TB] FAIL b2b_ctl k=%0d got=%b exp=%b", k,
                         {aOValid, aIdx, aLast, aReady}, {1'b1, 4'(ks), (ks == 15), (ks == 15)});
            end
            checks++;
            if (aBit !== expBits) begin
                errors++;
                $display("[TB] FAIL b2b_bits k=%0d got=%b exp=%b", k, aBit, expBits);
            end
            if (k == 15) begin
                @(posedge clk);
                #1;
                aValid = 1'b0;
            end
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ones0[c] != 5 || ones1[c] != 10) begin
                errors++;
                $display("[TB] FAIL b2b_ones ch=%0d got=%0d/%0d exp=5/10", c, ones0[c], ones1[c]);
            end
        end
        @(negedge clk);
        checks++;
        if ({aOValid, aReady} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_idle got=%b exp=%b", {aOValid, aReady}, 2'b01);
        end
    endtask

    task automatic test_stop();
        start_a({4{4'd15}});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({aOValid, aIdx, aLast, aBit} !== {1'b1, 4'(k), 1'b0, 4'hF}) begin
                errors++;
                $display("[TB] FAIL stop_run k=%0d got=%b exp=%b", k,
                         {aOValid, aIdx, aLast, aBit}, {1'b1, 4'(k), 1'b0, 4'hF});
            end
        end
        aStop = 1'b1;
        @(posedge clk);
        #1;
        aStop = 1'b0;
        @(negedge clk);
        checks++;
        if ({aOValid, aLast, aReady, aIdx, aBit} !== {1'b0, 1'b0, 1'b1, 4'd0, 4'h0}) begin
            errors++;
            $display("[TB] FAIL stop_abort got=%b exp=%b",
                     {aOValid, aLast, aReady, aIdx, aBit}, {1'b0, 1'b0, 1'b1, 4'd0, 4'h0});
        end
        // Restart while stop is high in IDLE: stop must be ignored there.
        @(posedge clk);
        #1;
        aX     = {4{4'd8}};
        aValid = 1'b1;
        aStop  = 1'b1;
        @(posedge clk);
        #1;
        aValid = 1'b0;
        aStop  = 1'b0;
        @(negedge clk);
        checks++;
        if ({aOValid, aIdx, aBit} !== {1'b1, 4'd0, 4'hF}) begin
            errors++;
            $display("[TB] FAIL stop_restart got=%b exp=%b", {aOValid, aIdx, aBit}, {1'b1, 4'd0, 4'hF});
        end
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
        end
        checks++;
        if ({aOValid, aIdx, aLast} !== {1'b1, 4'd15, 1'b1}) begin
            errors++;
            $display("[TB] FAIL stop_restart_end got=%b exp=%b", {aOValid, aIdx, aLast}, {1'b1, 4'd15, 1'b1});
        end
        // Stop and accept together at the final bit: the new stream wins.
        aX     = {4{4'd1}};
        aValid = 1'b1;
        aStop  = 1'b1;
        @(posedge clk);
        #1;
        aValid = 1'b0;
        aStop  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0 || k == 7) begin
                checks++;
                if ({aOValid, aIdx, aBit} !== {1'b1, 4'(k), ((k == 7) ? 4'hF : 4'h0)}) begin
                    errors++;
                    $display("[TB] FAIL stop_vs_accept k=%0d got=%b exp=%b", k,
                             {aOValid, aIdx, aBit}, {1'b1, 4'(k), ((k == 7) ? 4'hF : 4'h0)});
                end
            end
        end
        @(negedge clk);
        checks++;
        if (aOValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_final_idle got=%b exp=%b", aOValid, 1'b0);
        end
    endtask

    task automatic test_reset_midstream();
        start_a({4{4'd15}});
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
        end
        checks++;
        if ({aOValid, aIdx} !== {1'b1, 4'd9}) begin
            errors++;
            $display("[TB] FAIL midreset_pre got=%b exp=%b", {aOValid, aIdx}, {1'b1, 4'd9});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({aOValid, aBit, aIdx, aLast} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL midreset_async got=%b exp=%b", {aOValid, aBit, aIdx, aLast}, 10'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({aReady, aOValid, aIdx} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL midreset_release got=%b exp=%b", {aReady, aOValid, aIdx}, {1'b1, 1'b0, 4'd0});
        end
    endtask

    task automatic test_tail_off(input logic [2:0] x, input logic [6:0] mask, input int expOnes);
        int ones;
        ones = 0;
        @(posedge clk);
        #1;
        bX[0]  = x;
        bValid = 1'b1;
        @(posedge clk);
        #1;
        bValid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (bBit[0]) ones++;
            checks++;
            if ({bOValid, bIdx, bLast, bReady, bBit} !== {1'b1, 3'(k), (k == 6), (k == 6), mask[k]}) begin
                errors++;
                $display("[TB] FAIL tail_off x=%0d k=%0d got=%b exp=%b", x, k,
                         {bOValid, bIdx, bLast, bReady, bBit}, {1'b1, 3'(k), (k == 6), (k == 6), mask[k]});
            end
        end
        checks++;
        if (ones != expOnes) begin
            errors++;
            $display("[TB] FAIL tail_off_ones x=%0d got=%0d exp=%0d", x, ones, expOnes);
        end
        @(negedge clk);
        checks++;
        if ({bOValid, bReady} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL tail_off_idle x=%0d got=%b exp=%b", x, {bOValid, bReady}, 2'b01);
        end
    endtask

    task automatic test_random_sweep();
        logic [7:0][5:0] ops;
        int              ones[8];
        for (int s = 0; s < 500; s++) begin
            for (int c = 0; c < 8; c++) begin
                if (s == 0) ops[c] = 6'd63;
                else if (s == 1) ops[c] = 6'd0;
                else ops[c] = 6'($urandom_range(0, 63));
                ones[c] = 0;
            end
            @(posedge clk);
            #1;
            cX     = ops;
            cValid = 1'b1;
            @(posedge clk);
            #1;
            cValid = 1'b0;
            for (int k = 0; k < 64; k++) begin
                @(negedge clk);
                for (int c = 0; c < 8; c++) begin
                    if (cBit[c]) ones[c]++;
                    cX[c] = 6'($urandom_range(0, 63));
                end
                if (k == 63) begin
                    checks++;
                    if ({cOValid, cIdx, cLast} !== {1'b1, 6'd63, 1'b1}) begin
                        errors++;
                        $display("[TB] FAIL sweep_end s=%0d got=%b exp=%b", s,
                                 {cOValid, cIdx, cLast}, {1'b1, 6'd63, 1'b1});
                    end
                end
            end
            for (int c = 0; c < 8; c++) begin
                checks++;
                if (ones[c] != int'(ops[c])) begin
                    errors++;
                    $display("[TB] FAIL sweep_ones s=%0d ch=%0d got=%0d exp=%0d", s, c, ones[c], ops[c]);
                end
            end
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        aX = '0; aValid = 1'b0; aStop = 1'b0;
        bX = '0; bValid = 1'b0; bStop = 1'b0;
        cX = '0; cValid = 1'b0; cStop = 1'b0;
        test_reset();
        test_single_stream();
        test_back_to_back();
        test_stop();
        test_reset_midstream();
        test_tail_off(3'd7, 7'h7F, 7);
        test_tail_off(3'd3, 7'h2A, 3);
        test_tail_off(3'd4, 7'h55, 4);
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
